qea_host_sequencer: RTL and testbench

- Hardware host-side initiator for the QEA core; replaces the software/bench sequence that drives QEA's load, start and readback ports.
- Accepts a command (qubit count, instruction count), then streams gate-context words into QEA CTX RAM and initial amplitudes into STATE RAM.
- Pulses start, waits for complete and measures execution cycles.
- Reads the final state vector back out and emits it on a valid/ready stream.

---
 rtl/qea_host_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_qea_host_sequencer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qea_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : qea_host_sequencer
// Purpose  : Host-side initiator for the QEA core: loads CTX/STATE RAMs, runs
//            the core, times the run and streams the final state vector out.
// Revision : 1.0  initial release
// ============================================================================
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int RD_LAT                  = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_cmd_valid,
    output logic                                 o_cmd_ready,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_cmd_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    input  logic                                 i_sin_valid,
    output logic                                 o_sin_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_sin_data,
    output logic                                 o_sout_valid,
    input  logic                                 i_sout_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_sout_data,
    output logic                                 o_sout_last,
    output logic                                 o_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [31:0]                          o_exec_cycles
);

    localparam logic [3:0] c_ST_IDLE       = 4'd0;
    localparam logic [3:0] c_ST_LOAD_CTX   = 4'd1;
    localparam logic [3:0] c_ST_LOAD_STATE = 4'd2;
    localparam logic [3:0] c_ST_START      = 4'd3;
    localparam logic [3:0] c_ST_RUN        = 4'd4;
    localparam logic [3:0] c_ST_RD_ISSUE   = 4'd5;
    localparam logic [3:0] c_ST_RD_WAIT    = 4'd6;
    localparam logic [3:0] c_ST_RD_OUT     = 4'd7;
    localparam logic [3:0] c_ST_DONE       = 4'd8;

    localparam logic [MAX_QBIT_WIDTH-1:0]          c_PE_W      = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    localparam logic [MAX_QBIT_WIDTH-1:0]          c_QBIT_MIN  = MAX_QBIT_WIDTH'(PE_NUM_WIDTH + 1);
    localparam logic [31:0]                        c_QBIT_MAX  = 32'(PE_NUM_WIDTH + STATE_ADDR_WIDTH);
    localparam logic [GATE_CONTEXT_ADDR_WIDTH:0]   c_CTX_DEPTH = {1'b1, {GATE_CONTEXT_ADDR_WIDTH{1'b0}}};
    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] c_CTX_ONE   = GATE_CONTEXT_ADDR_WIDTH'(1);
    localparam logic [STATE_ADDR_WIDTH-1:0]        c_ST_ONE    = STATE_ADDR_WIDTH'(1);
    localparam logic [STATE_ADDR_WIDTH-1:0]        c_ALL_ONES  = '1;
    localparam logic [1:0]                         c_WAIT_LAST = 2'(RD_LAT - 1);

    logic [3:0]                         r_state;
    logic [3:0]                         w_next;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_cnt;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_last;
    logic [STATE_ADDR_WIDTH-1:0]        r_st_cnt;
    logic [STATE_ADDR_WIDTH-1:0]        r_st_last;
    logic [STATE_ADDR_WIDTH-1:0]        r_rd_addr;
    logic [1:0]                         r_wait;
    logic                               r_run_first;
    logic [31:0]                        r_exec;

    logic                               w_cmd_acc;
    logic                               w_cmd_ok;
    logic [MAX_QBIT_WIDTH-1:0]          w_shift;
    logic [STATE_ADDR_WIDTH-1:0]        w_state_last;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] w_ctx_last;
    logic                               w_ctx_hs;
    logic                               w_sin_hs;
    logic                               w_sout_hs;
    logic                               w_ctx_fin;
    logic                               w_sin_fin;
    logic                               w_rd_fin;
    logic                               w_wait_fin;
    logic                               w_complete_hit;

    // Next-value decode for the registered outputs
    logic                               w_cmd_ready_n;
    logic                               w_busy_n;
    logic                               w_ctx_ready_n;
    logic                               w_sin_ready_n;
    logic                               w_start_n;
    logic                               w_sout_valid_n;
    logic                               w_sout_last_n;
    logic                               w_done_n;
    logic                               w_err_n;
    logic                               w_rd_issue_n;
    logic [STATE_ADDR_WIDTH-1:0]        w_rd_addr_n;

    assign w_cmd_acc    = (r_state == c_ST_IDLE) && i_cmd_valid && o_cmd_ready;
    assign w_cmd_ok     = (i_cmd_qbit_num >= c_QBIT_MIN)
                       && (32'(i_cmd_qbit_num) <= c_QBIT_MAX)
                       && (i_cmd_ins_num <= c_CTX_DEPTH);
    assign w_shift      = i_cmd_qbit_num - c_PE_W;
    // N-1 is a run of ones below the shift position; the 2^16 depth case wraps to 0xFFFF.
    assign w_state_last = ~(c_ALL_ONES << w_shift);
    assign w_ctx_last   = i_cmd_ins_num[GATE_CONTEXT_ADDR_WIDTH-1:0] - c_CTX_ONE;

    assign w_ctx_hs       = (r_state == c_ST_LOAD_CTX) && o_ctx_ready && i_ctx_valid;
    assign w_sin_hs       = (r_state == c_ST_LOAD_STATE) && o_sin_ready && i_sin_valid;
    assign w_sout_hs      = (r_state == c_ST_RD_OUT) && o_sout_valid && i_sout_ready;
    assign w_ctx_fin      = w_ctx_hs && (r_ctx_cnt == r_ctx_last);
    assign w_sin_fin      = w_sin_hs && (r_st_cnt == r_st_last);
    assign w_rd_fin       = (r_rd_addr == r_st_last);
    assign w_wait_fin     = (r_wait == c_WAIT_LAST);
    assign w_complete_hit = (r_state == c_ST_RUN) && !r_run_first && i_complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_cmd_acc && w_cmd_ok) begin
                    w_next = (i_cmd_ins_num == '0) ? c_ST_LOAD_STATE : c_ST_LOAD_CTX;
                end
            end
            c_ST_LOAD_CTX:   if (w_ctx_fin)      w_next = c_ST_LOAD_STATE;
            c_ST_LOAD_STATE: if (w_sin_fin)      w_next = c_ST_START;
            c_ST_START:                          w_next = c_ST_RUN;
            c_ST_RUN:        if (w_complete_hit) w_next = c_ST_RD_ISSUE;
            c_ST_RD_ISSUE:                       w_next = c_ST_RD_WAIT;
            c_ST_RD_WAIT:    if (w_wait_fin)     w_next = c_ST_RD_OUT;
            c_ST_RD_OUT: begin
                if (w_sout_hs) begin
                    w_next = w_rd_fin ? c_ST_DONE : c_ST_RD_ISSUE;
                end
            end
            c_ST_DONE:                           w_next = c_ST_IDLE;
            default:                             w_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready_n  = (w_next == c_ST_IDLE);
        w_busy_n       = (w_next != c_ST_IDLE);
        w_ctx_ready_n  = (w_next == c_ST_LOAD_CTX);
        w_sin_ready_n  = (w_next == c_ST_LOAD_STATE);
        w_start_n      = (w_next == c_ST_START);
        w_sout_valid_n = (w_next == c_ST_RD_OUT);
        w_sout_last_n  = (w_next == c_ST_RD_OUT) && w_rd_fin;
        w_done_n       = (w_next == c_ST_DONE);
        w_err_n        = w_cmd_acc && !w_cmd_ok;
        w_rd_issue_n   = (w_next == c_ST_RD_ISSUE);
        w_rd_addr_n    = r_rd_addr;
        if (w_cmd_acc) begin
            w_rd_addr_n = '0;
        end else if (w_sout_hs && !w_rd_fin) begin
            w_rd_addr_n = r_rd_addr + c_ST_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctx_cnt   <= '0;
            r_ctx_last  <= '0;
            r_st_cnt    <= '0;
            r_st_last   <= '0;
            r_rd_addr   <= '0;
            r_wait      <= '0;
            r_run_first <= 1'b0;
            r_exec      <= '0;
        end else begin
            if (w_cmd_acc && w_cmd_ok) begin
                r_ctx_last <= w_ctx_last;
                r_st_last  <= w_state_last;
                r_ctx_cnt  <= '0;
                r_st_cnt   <= '0;
            end else begin
                if (w_ctx_hs) begin
                    r_ctx_cnt <= w_ctx_fin ? '0 : r_ctx_cnt + c_CTX_ONE;
                end
                if (w_sin_hs) begin
                    r_st_cnt <= w_sin_fin ? '0 : r_st_cnt + c_ST_ONE;
                end
            end
            r_rd_addr   <= w_rd_addr_n;
            r_wait      <= (r_state == c_ST_RD_WAIT && !w_wait_fin) ? r_wait + 2'd1 : 2'd0;
            r_run_first <= (r_state == c_ST_START);
            if (r_state == c_ST_START) begin
                r_exec <= '0;
            end else if (r_state == c_ST_RUN) begin
                r_exec <= r_exec + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_cmd_ready   <= 1'b1;
            o_busy        <= 1'b0;
            o_ctx_ready   <= 1'b0;
            o_sin_ready   <= 1'b0;
            o_start       <= 1'b0;
            o_sout_valid  <= 1'b0;
            o_sout_last   <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
            o_ctx_en      <= 1'b0;
            o_ctx_wea     <= 1'b0;
            o_state_ena   <= 1'b0;
            o_state_wea   <= 1'b0;
            o_ctx_addr    <= '0;
            o_ctx_data    <= '0;
            o_state_addra <= '0;
            o_state_dina  <= '0;
            o_sout_data   <= '0;
            o_qbit_num    <= '0;
            o_exec_cycles <= '0;
        end else begin
            o_cmd_ready  <= w_cmd_ready_n;
            o_busy       <= w_busy_n;
            o_ctx_ready  <= w_ctx_ready_n;
            o_sin_ready  <= w_sin_ready_n;
            o_start      <= w_start_n;
            o_sout_valid <= w_sout_valid_n;
            o_sout_last  <= w_sout_last_n;
            o_done       <= w_done_n;
            o_err        <= w_err_n;
            o_ctx_en     <= w_ctx_hs;
            o_ctx_wea    <= w_ctx_hs;
            o_state_ena  <= w_sin_hs || w_rd_issue_n;
            o_state_wea  <= w_sin_hs;
            if (w_ctx_hs) begin
                o_ctx_addr <= r_ctx_cnt;
                o_ctx_data <= i_ctx_data;
            end
            if (w_sin_hs) begin
                o_state_addra <= r_st_cnt;
                o_state_dina  <= i_sin_data;
            end else if (w_rd_issue_n) begin
                o_state_addra <= w_rd_addr_n;
            end
            if (r_state == c_ST_RD_WAIT && w_wait_fin) begin
                o_sout_data <= i_state_dout;
            end
            if (w_cmd_acc && w_cmd_ok) begin
                o_qbit_num <= i_cmd_qbit_num;
            end
            if (w_complete_hit) begin
                o_exec_cycles <= r_exec;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qea_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qea_host_sequencer
// Purpose  : Directed self-checking bench for qea_host_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_qea_host_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [5:0]   i_cmd_qbit_num;
    logic [16:0]  i_cmd_ins_num;
    logic         i_ctx_valid;
    logic         o_ctx_ready;
    logic [63:0]  i_ctx_data;
    logic         i_sin_valid;
    logic         o_sin_ready;
    logic [255:0] i_sin_data;
    logic         o_sout_valid;
    logic         i_sout_ready;
    logic [255:0] o_sout_data;
    logic         o_sout_last;
    logic         o_start;
    logic [5:0]   o_qbit_num;
    logic         o_ctx_en;
    logic         o_ctx_wea;
    logic [15:0]  o_ctx_addr;
    logic [63:0]  o_ctx_data;
    logic         o_state_ena;
    logic         o_state_wea;
    logic [15:0]  o_state_addra;
    logic [255:0] o_state_dina;
    logic         i_complete;
    logic [255:0] i_state_dout;
    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic [31:0]  o_exec_cycles;

    int checks = 0;
    int errors = 0;

    qea_host_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_qbit_num (i_cmd_qbit_num),
        .i_cmd_ins_num  (i_cmd_ins_num),
        .i_ctx_valid    (i_ctx_valid),
        .o_ctx_ready    (o_ctx_ready),
        .i_ctx_data     (i_ctx_data),
        .i_sin_valid    (i_sin_valid),
        .o_sin_ready    (o_sin_ready),
        .i_sin_data     (i_sin_data),
        .o_sout_valid   (o_sout_valid),
        .i_sout_ready   (i_sout_ready),
        .o_sout_data    (o_sout_data),
        .o_sout_last    (o_sout_last),
        .o_start        (o_start),
        .o_qbit_num     (o_qbit_num),
        .o_ctx_en       (o_ctx_en),
        .o_ctx_wea      (o_ctx_wea),
        .o_ctx_addr     (o_ctx_addr),
        .o_ctx_data     (o_ctx_data),
        .o_state_ena    (o_state_ena),
        .o_state_wea    (o_state_wea),
        .o_state_addra  (o_state_addra),
        .o_state_dina   (o_state_dina),
        .i_complete     (i_complete),
        .i_state_dout   (i_state_dout),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_exec_cycles  (o_exec_cycles)
    );

    always #5 clk = ~clk;

    // QEA STATE RAM stand-in: one-cycle read returning the address in every lane
    always @(posedge clk) begin
        if (o_state_ena && !o_state_wea) begin
            i_state_dout <= {4{48'h0, o_state_addra}};
        end
    end

    function automatic logic [63:0] ctx_word(input int k);
        return {32'hC0DE_0000, 32'(k)};
    endfunction

    function automatic logic [255:0] sin_word(input int k, input bit amp);
        if (amp) return (k == 0) ? {64'h40000000_00000000, 192'h0} : 256'h0;
        return {8{32'(k) ^ 32'h5A5A_0000}};
    endfunction

    function automatic logic [255:0] rb_word(input int k);
        logic [15:0] a;
        a = 16'(k);
        return {4{48'h0, a}};
    endfunction

    task automatic send_cmd(input logic [5:0] q, input logic [16:0] ins);
        i_cmd_valid    = 1'b1;
        i_cmd_qbit_num = q;
        i_cmd_ins_num  = ins;
        @(posedge clk); #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_busy: got ready=%b busy=%b required 1 0", o_cmd_ready, o_busy);
        end
        checks++;
        if ({o_start, o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_sout_valid, o_sout_last,
             o_done, o_err, o_ctx_ready, o_sin_ready} !== 11'b0) begin
            errors++;
            $display("FAIL reset_strobes: got start=%b ctx_en=%b st_ena=%b sout_v=%b done=%b err=%b required all 0",
                     o_start, o_ctx_en, o_state_ena, o_sout_valid, o_done, o_err);
        end
        checks++;
        if (o_exec_cycles !== 32'd0 || o_qbit_num !== 6'd0 || o_ctx_addr !== 16'd0 ||
            o_state_addra !== 16'd0 || o_sout_data !== 256'd0) begin
            errors++;
            $display("FAIL reset_regs: got exec=%0d qbit=%0d ctx_addr=%0d st_addr=%0d required all 0",
                     o_exec_cycles, o_qbit_num, o_ctx_addr, o_state_addra);
        end
    endtask

    task automatic test_ctx_load(input int n, input bit gaps);
        int sent = 0;
        int bad = 0;
        int cyc = 0;
        int first_bad = -1;
        logic hs;
        i_ctx_valid = (n > 0);
        i_ctx_data  = ctx_word(0);
        while (sent < n && cyc < 4 * n + 20) begin
            hs = o_ctx_ready && i_ctx_valid;
            @(posedge clk); #1;
            cyc++;
            if (o_ctx_en !== hs || o_ctx_wea !== hs ||
                (hs && (o_ctx_addr !== 16'(sent) || o_ctx_data !== ctx_word(sent)))) begin
                bad++;
                if (first_bad < 0) first_bad = cyc;
            end
            if (hs) sent++;
            i_ctx_valid = (sent < n) && !(gaps && (cyc % 3 == 2));
            i_ctx_data  = ctx_word(sent);
        end
        i_ctx_valid = 1'b0;
        checks++;
        if (sent !== n) begin
            errors++;
            $display("FAIL ctx_write_count: got %0d required %0d", sent, n);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ctx_write_stream: got %0d bad cycles (first at %0d) required 0", bad, first_bad);
        end
        if (!gaps) begin
            checks++;
            if (cyc !== n) begin
                errors++;
                $display("FAIL ctx_consecutive: got %0d cycles required %0d", cyc, n);
            end
        end
    endtask

    task automatic test_state_load(input int n, input bit gaps, input bit amp, input int abort_at);
        int sent = 0;
        int bad = 0;
        int cyc = 0;
        int first_bad = -1;
        int target;
        logic hs;
        target = (abort_at >= 0) ? abort_at : n;
        i_sin_valid = (n > 0);
        i_sin_data  = sin_word(0, amp);
        while (sent < target && cyc < 4 * n + 20) begin
            hs = o_sin_ready && i_sin_valid;
            @(posedge clk); #1;
            cyc++;
            if (o_state_ena !== hs || o_state_wea !== hs || o_ctx_en !== 1'b0 ||
                (hs && (o_state_addra !== 16'(sent) || o_state_dina !== sin_word(sent, amp)))) begin
                bad++;
                if (first_bad < 0) first_bad = cyc;
            end
            if (hs) sent++;
            i_sin_valid = (sent < n) && !(gaps && (cyc % 3 == 2));
            i_sin_data  = sin_word(sent, amp);
        end
        i_sin_valid = 1'b0;
        checks++;
        if (sent !== target) begin
            errors++;
            $display("FAIL state_write_count: got %0d required %0d", sent, target);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL state_write_stream: got %0d bad cycles (first at %0d) required 0", bad, first_bad);
        end
        if (!gaps && abort_at < 0) begin
            checks++;
            if (cyc !== n || o_start !== 1'b1) begin
                errors++;
                $display("FAIL state_consecutive_start: got %0d cycles start=%b required %0d cycles start=1",
                         cyc, o_start, n);
            end
        end
    endtask

    // Entered at the cycle o_start is high; complete rises on RUN cycle delay-1.
    task automatic test_complete_timing(input int delay, input logic stale);
        int starts = 0;
        i_complete = stale;
        for (int k = 1; k <= delay; k++) begin
            @(posedge clk); #1;
            starts += int'(o_start);
            i_complete = (k == 1) ? stale : (k == delay);
        end
        @(posedge clk); #1;
        i_complete = 1'b0;
        checks++;
        if (o_exec_cycles !== 32'(delay - 1)) begin
            errors++;
            $display("FAIL exec_cycles: got %0d required %0d", o_exec_cycles, delay - 1);
        end
        checks++;
        if (starts !== 0 || o_state_ena !== 1'b1 || o_state_wea !== 1'b0 || o_state_addra !== 16'd0) begin
            errors++;
            $display("FAIL run_to_read: got extra_starts=%0d ena=%b wea=%b addr=%0d required 0 1 0 0",
                     starts, o_state_ena, o_state_wea, o_state_addra);
        end
    endtask

    task automatic test_readback(input int n);
        int w = 0;
        int bad = 0;
        int stall_bad = 0;
        int cyc = 0;
        logic v, r, l;
        logic [255:0] d;
        i_sout_ready = 1'b1;
        while (w < n && cyc < 8 * n + 50) begin
            v = o_sout_valid;
            r = i_sout_ready;
            l = o_sout_last;
            d = o_sout_data;
            if (v && r) begin
                if (d !== rb_word(w) || l !== (w == n - 1)) bad++;
                w++;
            end
            @(posedge clk); #1;
            cyc++;
            if (v && !r && (o_sout_valid !== 1'b1 || o_sout_data !== d || o_sout_last !== l)) stall_bad++;
            i_sout_ready = ~i_sout_ready;
        end
        i_sout_ready = 1'b0;
        checks++;
        if (w !== n) begin
            errors++;
            $display("FAIL readback_count: got %0d words required %0d", w, n);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL readback_data_last: got %0d bad words required 0", bad);
        end
        checks++;
        if (stall_bad !== 0) begin
            errors++;
            $display("FAIL readback_stall_hold: got %0d unstable stalls required 0", stall_bad);
        end
        checks++;
        if (o_done !== 1'b1 || o_sout_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b valid=%b required 1 0", o_done, o_sout_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (o_done !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: got done=%b ready=%b busy=%b required 0 1 0", o_done, o_cmd_ready, o_busy);
        end
    endtask

    task automatic test_full_run();
        send_cmd(6'd11, 17'd1959);
        checks++;
        if (o_busy !== 1'b1 || o_cmd_ready !== 1'b0 || o_ctx_ready !== 1'b1 || o_qbit_num !== 6'd11) begin
            errors++;
            $display("FAIL accept_11q: got busy=%b ready=%b ctx_ready=%b qbit=%0d required 1 0 1 11",
                     o_busy, o_cmd_ready, o_ctx_ready, o_qbit_num);
        end
        test_ctx_load(1959, 1'b0);
        test_state_load(512, 1'b0, 1'b1, -1);
        test_complete_timing(100, 1'b1);
        test_readback(512);
    endtask

    task automatic test_rejects();
        logic [5:0]  q[3];
        logic [16:0] ins[3];
        q   = '{6'd2, 6'd19, 6'd11};
        ins = '{17'd10, 17'd10, 17'd65537};
        for (int i = 0; i < 3; i++) begin
            send_cmd(q[i], ins[i]);
            checks++;
            if (o_err !== 1'b1 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_qbit_num !== 6'd11) begin
                errors++;
                $display("FAIL reject_%0d: got err=%b ready=%b busy=%b qbit=%0d required 1 1 0 11",
                         i, o_err, o_cmd_ready, o_busy, o_qbit_num);
            end
            @(posedge clk); #1;
            checks++;
            if (o_err !== 1'b0 || {o_ctx_en, o_state_ena, o_start, o_ctx_ready, o_sin_ready} !== 5'b0) begin
                errors++;
                $display("FAIL reject_quiet_%0d: got err=%b ctx_en=%b st_ena=%b start=%b required all 0",
                         i, o_err, o_ctx_en, o_state_ena, o_start);
            end
        end
    endtask

    task automatic test_ins_zero();
        send_cmd(6'd3, 17'd0);
        checks++;
        if (o_sin_ready !== 1'b1 || o_ctx_ready !== 1'b0 || o_ctx_en !== 1'b0 || o_qbit_num !== 6'd3) begin
            errors++;
            $display("FAIL ins_zero_skip: got sin_ready=%b ctx_ready=%b ctx_en=%b qbit=%0d required 1 0 0 3",
                     o_sin_ready, o_ctx_ready, o_ctx_en, o_qbit_num);
        end
        test_state_load(2, 1'b0, 1'b0, -1);
        test_complete_timing(5, 1'b0);
        test_readback(2);
    endtask

    task automatic test_input_gaps();
        send_cmd(6'd5, 17'd20);
        test_ctx_load(20, 1'b1);
        test_state_load(8, 1'b1, 1'b0, -1);
        checks++;
        if (o_start !== 1'b1) begin
            errors++;
            $display("FAIL gaps_start: got start=%b required 1", o_start);
        end
        test_complete_timing(3, 1'b1);
        test_readback(8);
    endtask

    task automatic test_reset_mid();
        send_cmd(6'd11, 17'd10);
        test_ctx_load(10, 1'b0);
        test_state_load(512, 1'b0, 1'b0, 100);
        i_sin_valid = 1'b1;
        i_sin_data  = sin_word(100, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({o_state_ena, o_state_wea, o_ctx_en, o_start, o_sout_valid, o_sin_ready} !== 6'b0 ||
            o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_abort: got st_ena=%b sin_ready=%b busy=%b ready=%b required 0 0 0 1",
                     o_state_ena, o_sin_ready, o_busy, o_cmd_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (o_state_ena !== 1'b0 || o_state_wea !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_write: got ena=%b wea=%b required 0 0", o_state_ena, o_state_wea);
        end
        i_sin_valid = 1'b0;
        send_cmd(6'd4, 17'd3);
        test_ctx_load(3, 1'b0);
        test_state_load(4, 1'b0, 1'b0, -1);
        test_complete_timing(10, 1'b0);
        test_readback(4);
    endtask

    initial begin
        rst            = 1'b1;
        i_cmd_valid    = 1'b0;
        i_cmd_qbit_num = '0;
        i_cmd_ins_num  = '0;
        i_ctx_valid    = 1'b0;
        i_ctx_data     = '0;
        i_sin_valid    = 1'b0;
        i_sin_data     = '0;
        i_sout_ready   = 1'b0;
        i_complete     = 1'b0;
        test_reset();
        test_full_run();
        test_rejects();
        test_ins_zero();
        test_input_gaps();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
